// File: rtl/conf_add_rr_scheduler.sv
// conf_add_rr_scheduler: round-robin scheduler sharing one configurable-precision adder
// among N_REQ requesters, one operation in flight, result returned over valid/ready.
module conf_add_rr_scheduler #(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 32,
    parameter int CONF_W   = 4,
    parameter int MAX_CONF = 4,
    parameter int ADD_LAT  = 1,
    parameter int ID_W     = $clog2(N_REQ)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [N_REQ-1:0]         i_req_valid,
    output logic [N_REQ-1:0]         o_req_ready,
    input  logic [N_REQ*DATA_W-1:0]  i_req_a,
    input  logic [N_REQ*DATA_W-1:0]  i_req_b,
    input  logic [N_REQ*CONF_W-1:0]  i_req_conf,
    output logic [DATA_W-1:0]        o_add_a,
    output logic [DATA_W-1:0]        o_add_b,
    output logic [CONF_W-1:0]        o_add_conf,
    input  logic [DATA_W-1:0]        i_add_c,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [DATA_W-1:0]        o_rsp_c,
    output logic [ID_W-1:0]          o_rsp_id,
    output logic                     o_err_conf
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t            r_state, w_state_nxt;
    logic [ID_W-1:0]   r_rr_ptr, r_rsp_id, w_grant;
    logic [2:0]        r_lat_cnt;
    logic [DATA_W-1:0] r_add_a, r_add_b, r_rsp_c;
    logic [CONF_W-1:0] r_add_conf, w_conf;
    logic              r_err_conf, w_accept, w_conf_bad, w_exec_done;
    // Descending scan so the requester closest after r_rr_ptr is assigned last and wins.
    always_comb begin
        w_grant = '0;
        for (int k = N_REQ; k >= 1; k--)
            if (i_req_valid[(int'(r_rr_ptr) + k) % N_REQ])
                w_grant = ID_W'((int'(r_rr_ptr) + k) % N_REQ);
    end
    assign w_accept    = (r_state == IDLE) && (|i_req_valid) && !i_rst;
    assign w_conf      = i_req_conf[w_grant*CONF_W +: CONF_W];
    assign w_conf_bad  = int'(w_conf) > MAX_CONF;
    assign w_exec_done = (r_state == EXEC) && (r_lat_cnt == '0);
    assign o_req_ready = w_accept ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_grant) : '0;
    always_comb begin
        w_state_nxt = w_accept ? EXEC :
                      w_exec_done ? RESP :
                      (r_state == RESP && i_rsp_ready) ? IDLE : r_state;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else r_state <= w_state_nxt;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rr_ptr   <= ID_W'(N_REQ - 1);
            r_rsp_id   <= '0;
            r_lat_cnt  <= '0;
            r_add_a    <= '0;
            r_add_b    <= '0;
            r_add_conf <= '0;
            r_rsp_c    <= '0;
            r_err_conf <= 1'b0;
        end else begin
            r_err_conf <= w_accept && w_conf_bad;
            if (w_accept) begin
                r_add_a    <= i_req_a[w_grant*DATA_W +: DATA_W];
                r_add_b    <= i_req_b[w_grant*DATA_W +: DATA_W];
                r_add_conf <= w_conf_bad ? '0 : w_conf;
                r_rsp_id   <= w_grant;
                r_rr_ptr   <= w_grant;
                r_lat_cnt  <= 3'(ADD_LAT);
            end else if (r_state == EXEC && r_lat_cnt != '0) begin
                r_lat_cnt <= r_lat_cnt - 1'b1;
            end
            if (w_exec_done) r_rsp_c <= i_add_c;
        end
    end
    assign o_add_a     = r_add_a;
    assign o_add_b     = r_add_b;
    assign o_add_conf  = r_add_conf;
    assign o_rsp_valid = (r_state == RESP);
    assign o_rsp_c     = r_rsp_c;
    assign o_rsp_id    = r_rsp_id;
    assign o_err_conf  = r_err_conf;
endmodule
